// File: rtl/order_book_pkg.sv
// Shared definitions for the order-book front end.
//   MSG_BYTES / MSG_W  : message size in bytes / bits
//   REQ_*              : request-type codes that may start a message
//   asm_state_t        : assembler FSM states
//   is_valid_req_type  : true when a byte is one of the REQ_* codes
package order_book_pkg;

  localparam int MSG_BYTES = 40;
  localparam int MSG_W     = 8 * MSG_BYTES;

  localparam logic [7:0] REQ_ADD      = 8'h41;
  localparam logic [7:0] REQ_DELETE   = 8'h44;
  localparam logic [7:0] REQ_MODIFY   = 8'h4D;
  localparam logic [7:0] REQ_SNAPSHOT = 8'h53;

  typedef logic [MSG_W-1:0] order_msg_t;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } asm_state_t;

  function automatic logic is_valid_req_type(input logic [7:0] b);
    return (b == REQ_ADD) || (b == REQ_DELETE) ||
           (b == REQ_MODIFY) || (b == REQ_SNAPSHOT);
  endfunction

endpackage

// File: rtl/order_msg_fifo.sv
// First-word-fall-through FIFO for completed messages.
//   clk, reset : clock, synchronous active-high reset
//   push/wr_data : write one word (ignored when full)
//   pop          : drop the head word (ignored when empty)
//   rd_data      : head word, zero when empty
//   full/empty/count : occupancy
// DEPTH must be a power of two so the pointers wrap naturally.
module order_msg_fifo #(
  parameter int WIDTH = 320,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             push_ok, pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rd_data = empty ? '0 : mem[rd_ptr];

  // Storage needs no reset: the output is masked while empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/order_msg_assembler.sv
// Byte-serial order message assembler (MSB byte first) feeding a FWFT FIFO.
//   clk, reset       : clock, synchronous active-high reset
//   in_valid/in_data/in_ready : byte stream, accepted when valid && ready
//   msg_pop          : consume head message (ignored when empty)
//   ff_buffer        : head message, byte 0 in the top byte, zero when empty
//   buffer_not_empty : FIFO holds at least one message
//   fifo_count       : messages held
//   drop_count       : discarded bytes/partial messages, saturating
// Optional: define ORDER_ASM_TIMEOUT_EN to discard a partial message after
// TIMEOUT_CYCLES idle cycles in COLLECT (FIFO-full stalls do not count).
module order_msg_assembler #(
  parameter int MSG_BYTES  = order_book_pkg::MSG_BYTES,
  parameter int FIFO_DEPTH = 4
`ifdef ORDER_ASM_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 64
`endif
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic [7:0]                    in_data,
  output logic                          in_ready,
  input  logic                          msg_pop,
  output logic [8*MSG_BYTES-1:0]        ff_buffer,
  output logic                          buffer_not_empty,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [15:0]                   drop_count
);
  import order_book_pkg::*;

  localparam int WORD_W = 8 * MSG_BYTES;
  localparam int SH_W   = WORD_W - 8;          // holds the first MSG_BYTES-1 bytes
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int BC_W   = $clog2(MSG_BYTES);
`ifdef ORDER_ASM_TIMEOUT_EN
  localparam int IC_W   = $clog2(TIMEOUT_CYCLES + 1);
  logic [IC_W-1:0] idle_cnt;
`endif

  asm_state_t        state;
  logic [SH_W-1:0]   shreg;
  logic [BC_W-1:0]   byte_cnt;
  logic              accept, push, pop;
  logic              fifo_full, fifo_empty;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [WORD_W-1:0] wr_word;

  assign accept  = in_valid && in_ready;
  assign push    = accept && (state == ST_COLLECT) &&
                   (byte_cnt == BC_W'(MSG_BYTES - 1)) && !fifo_full;
  assign pop     = msg_pop && !fifo_empty;
  assign wr_word = {shreg, in_data};
  // Occupancy after this edge; in_ready is registered from it so a full
  // FIFO blocks the very next byte and a pop reopens input one cycle later.
  assign cnt_nxt = fifo_count + CNT_W'(push) - CNT_W'(pop);
  assign buffer_not_empty = !fifo_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      shreg      <= '0;
      byte_cnt   <= '0;
      in_ready   <= 1'b0;
      drop_count <= '0;
`ifdef ORDER_ASM_TIMEOUT_EN
      idle_cnt   <= '0;
`endif
    end else begin
      in_ready <= (cnt_nxt != CNT_W'(FIFO_DEPTH));
      case (state)
        ST_IDLE: begin
`ifdef ORDER_ASM_TIMEOUT_EN
          idle_cnt <= '0;
`endif
          if (accept) begin
            if (is_valid_req_type(in_data)) begin
              shreg    <= SH_W'(in_data);
              byte_cnt <= BC_W'(1);
              state    <= ST_COLLECT;
            end else if (drop_count != '1) begin
              drop_count <= drop_count + 16'd1;
            end
          end
        end
        ST_COLLECT: begin
          // Type codes here are payload; there is no resync mid-message.
          if (accept) begin
            shreg    <= {shreg[SH_W-9:0], in_data};
            byte_cnt <= byte_cnt + 1'b1;
            if (push) begin
              byte_cnt <= '0;
              state    <= ST_IDLE;
            end
          end
`ifdef ORDER_ASM_TIMEOUT_EN
          if (accept) begin
            idle_cnt <= '0;
          end else if (in_ready) begin
            if (idle_cnt == IC_W'(TIMEOUT_CYCLES - 1)) begin
              idle_cnt <= '0;
              byte_cnt <= '0;
              state    <= ST_IDLE;
              if (drop_count != '1) drop_count <= drop_count + 16'd1;
            end else begin
              idle_cnt <= idle_cnt + 1'b1;
            end
          end
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  order_msg_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .wr_data (wr_word),
    .pop     (pop),
    .rd_data (ff_buffer),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

endmodule

// File: tb/tb_order_msg_assembler.sv
module tb_order_msg_assembler;
  import order_book_pkg::*;

  typedef logic [7:0] msg_bytes_t [40];

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic [7:0]   in_data = 8'h00;
  logic         in_ready;
  logic         msg_pop = 1'b0;
  logic [319:0] ff_buffer;
  logic         buffer_not_empty;
  logic [2:0]   fifo_count;
  logic [15:0]  drop_count;

  order_msg_assembler dut (
    .clk              (clk),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_data          (in_data),
    .in_ready         (in_ready),
    .msg_pop          (msg_pop),
    .ff_buffer        (ff_buffer),
    .buffer_not_empty (buffer_not_empty),
    .fifo_count       (fifo_count),
    .drop_count       (drop_count)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference model: list of bytes of the message in flight, queue of
  // completed messages, drop counter.
  order_msg_t exp_q[$];
  logic [7:0] cur[$];
  bit         collecting = 0;
  int         mdrop = 0;

  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic order_msg_t pack(input msg_bytes_t b);
    order_msg_t m;
    for (int i = 0; i < 40; i++) m[319-8*i -: 8] = b[i];
    return m;
  endfunction

  task automatic model_byte(input logic [7:0] d);
    if (!collecting) begin
      if (d inside {8'h41, 8'h44, 8'h4D, 8'h53}) begin
        cur.delete();
        cur.push_back(d);
        collecting = 1;
      end else if (mdrop < 16'hFFFF) begin
        mdrop++;
      end
    end else begin
      cur.push_back(d);
      if (cur.size() == 40) begin
        msg_bytes_t b;
        for (int i = 0; i < 40; i++) b[i] = cur[i];
        exp_q.push_back(pack(b));
        cur.delete();
        collecting = 0;
      end
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    cur.delete();
    collecting = 0;
    mdrop = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".in_ready"}, in_ready, exp_q.size() < 4);
    chk({tag, ".count"}, fifo_count, exp_q.size());
    chk({tag, ".not_empty"}, buffer_not_empty, exp_q.size() != 0);
    chk({tag, ".head"}, ff_buffer, (exp_q.size() != 0) ? exp_q[0] : '0);
    chk({tag, ".drops"}, drop_count, mdrop);
  endtask

  // One clock: drive at the falling edge, update model at the rising edge,
  // return at the next falling edge.
  task automatic cycle(input logic v, input logic [7:0] d, input logic p, output bit acc);
    bit rdy;
    in_valid = v; in_data = d; msg_pop = p;
    rdy = in_ready;
    @(posedge clk);
    if (p && exp_q.size() > 0) void'(exp_q.pop_front());
    acc = v && rdy;
    if (acc) model_byte(d);
    @(negedge clk);
    in_valid = 1'b0; msg_pop = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit acc = 0;
    int n = 0;
    while (!acc && n < 200) begin
      cycle(1'b1, b, 1'b0, acc);
      n++;
    end
    chk("byte_accepted", acc, 1'b1);
  endtask

  task automatic send_msg(input msg_bytes_t m);
    for (int i = 0; i < 40; i++) send_byte(m[i]);
  endtask

  task automatic gen_msg(output msg_bytes_t m);
    logic [7:0] types [4] = '{8'h41, 8'h44, 8'h4D, 8'h53};
    m[0] = types[$urandom_range(0, 3)];
    for (int i = 1; i < 40; i++) m[i] = 8'($urandom);
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; msg_pop = 1'b0;
    @(negedge clk);
    chk("rst.in_ready", in_ready, 1'b0);
    chk("rst.count", fifo_count, 3'd0);
    reset = 1'b0;
    @(negedge clk);
    model_clear();
    check_all("post_rst");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    msg_bytes_t m1, ma, mb, m5;
    msg_bytes_t mq [4];
    bit acc;

    m1 = '{8'h44,8'h78,8'h56,8'h34,8'h12,8'h78,8'h56,8'h34,8'h12,8'h00,
           8'h01,8'h03,8'hEA,8'h08,8'h00,8'h00,8'h06,8'h00,8'h00,8'h00,
           8'h00,8'h42,8'h00,8'h00,8'h00,8'h64,8'h00,8'h00,8'h00,8'h00,
           8'h00,8'h00,8'h00,8'h55,8'h06,8'h00,8'h00,8'h05,8'h00,8'h00};

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset.in_ready", in_ready, 1'b0);
    chk("reset.not_empty", buffer_not_empty, 1'b0);
    chk("reset.head", ff_buffer, 320'd0);
    chk("reset.drops", drop_count, 16'd0);
    reset = 1'b0;
    @(negedge clk);
    model_clear();
    chk("reset.ready_after", in_ready, 1'b1);

    // Single message, in_valid held high
    send_msg(m1);
    chk("single.not_empty", buffer_not_empty, 1'b1);
    chk("single.count", fifo_count, 3'd1);
    chk("single.top_byte", ff_buffer[319:312], 8'h44);
    chk("single.low_word", ff_buffer[31:0], 32'h00050000);
    chk("single.word", ff_buffer, pack(m1));
    cycle(1'b0, 8'h00, 1'b1, acc);
    chk("single.popped", buffer_not_empty, 1'b0);
    check_all("single");

    // Resync on non-type bytes
    do_reset();
    send_byte(8'h00);
    send_byte(8'hFF);
    gen_msg(ma); ma[0] = 8'h53;
    send_msg(ma);
    chk("resync.drops", drop_count, 16'd2);
    chk("resync.type", ff_buffer[319:312], 8'h53);
    check_all("resync");

    // Full FIFO / backpressure
    do_reset();
    for (int k = 0; k < 4; k++) begin gen_msg(mq[k]); send_msg(mq[k]); end
    chk("full.ready", in_ready, 1'b0);
    chk("full.count", fifo_count, 3'd4);
    gen_msg(m5);
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, m5[0], 1'b0, acc);
      chk("full.stall_ready", in_ready, 1'b0);
      chk("full.stall_count", fifo_count, 3'd4);
    end
    cycle(1'b1, m5[0], 1'b1, acc);
    chk("full.ready_after_pop", in_ready, 1'b1);
    chk("full.count_after_pop", fifo_count, 3'd3);
    send_msg(m5);
    check_all("full.fifth");
    for (int k = 0; k < 3; k++) cycle(1'b0, 8'h00, 1'b1, acc);
    chk("full.fifth_intact", ff_buffer, pack(m5));
    check_all("full.drain");

    // Push and pop in the same cycle
    do_reset();
    gen_msg(ma); gen_msg(mb);
    send_msg(ma);
    for (int i = 0; i < 39; i++) send_byte(mb[i]);
    cycle(1'b1, mb[39], 1'b1, acc);
    chk("pushpop.acc", acc, 1'b1);
    chk("pushpop.count", fifo_count, 3'd1);
    chk("pushpop.head", ff_buffer, pack(mb));

    // Reset in the middle of a message
    do_reset();
    gen_msg(ma); gen_msg(mb);
    for (int i = 0; i < 20; i++) send_byte(ma[i]);
    do_reset();
    send_msg(mb);
    chk("midrst.count", fifo_count, 3'd1);
    chk("midrst.head", ff_buffer, pack(mb));
    repeat (3) cycle(1'b0, 8'h00, 1'b0, acc);
    chk("midrst.count_stable", fifo_count, 3'd1);

    // Idle in the middle of a message
    do_reset();
    gen_msg(ma);
    for (int i = 0; i < 10; i++) send_byte(ma[i]);
    repeat (63) cycle(1'b0, 8'h00, 1'b0, acc);
    chk("idle.drops_63", drop_count, 16'd0);
    cycle(1'b0, 8'h00, 1'b0, acc);
`ifdef ORDER_ASM_TIMEOUT_EN
    mdrop++; cur.delete(); collecting = 0;
    chk("timeout.drops", drop_count, 16'd1);
    gen_msg(mb);
    send_msg(mb);
    chk("timeout.next_msg", ff_buffer, pack(mb));
`else
    chk("noto.drops", drop_count, 16'd0);
    for (int i = 10; i < 40; i++) send_byte(ma[i]);
    chk("noto.completed", ff_buffer, pack(ma));
`endif
    check_all("idle");

    // Randomised traffic with random pops
    do_reset();
    for (int c = 0; c < 400; c++) begin
      logic       v, p;
      logic [7:0] d;
      v = ($urandom_range(0, 9) < 8);
      p = ($urandom_range(0, 9) < 2);
      if (!collecting && $urandom_range(0, 3) == 0) d = 8'($urandom);
      else if (!collecting) d = 8'h41 + 8'($urandom_range(0, 1) * 3);
      else d = 8'($urandom);
      cycle(v, d, p, acc);
      check_all("rand");
    end
    while (exp_q.size() > 0) cycle(1'b0, 8'h00, 1'b1, acc);
    check_all("rand.drained");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
